mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//  Iterative MULT/MULTU/DIV/DIVU unit fed directly by register-file outA/outB (srcA/srcB).
//  Holds architectural HI/LO. Runs one radix-2 step per clock (shift-add multiply, restoring divide).
//  The controller stalls on busy; MFHI/MFLO read hi/lo.
// PARAMETERS
//  WIDTH   32   operand width; HI/LO width; iteration count
// PORTS
//  clk      in   1      clock, rising edge
//  reset    in   1      asynchronous, active-low reset
//  start    in   1      begin op; accepted only in IDLE
//  op       in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  srcA     in   WIDTH  multiplicand / dividend; MTHI/MTLO data
//  srcB     in   WIDTH  multiplier / divisor
//  mtHi     in   1      write srcA to HI; only in IDLE
//  mtLo     in   1      write srcA to LO; only in IDLE
//  busy     out  1      op in flight
//  done     out  1      one-cycle pulse on the cycle HI/LO update
//  divZero  out  1      valid with done; divisor was 0
//  hi       out  WIDTH  HI register
//  lo       out  WIDTH  LO register
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; hi=lo=0; busy=done=divZero=0; iteration counter=0.
//  States: IDLE -> RUN -> FIN -> IDLE.
//  IDLE: start=1 at edge N.
//   - Latch |srcA| and |srcB| (signed ops) or raw values (unsigned ops).
//   - Latch the result signs; clear the accumulator; cnt=0; go to RUN.
//  RUN: one step per edge; cnt increments; after WIDTH steps (edges N+1..N+WIDTH) go to FIN.
//  FIN (edge N+WIDTH+1): sign-correct, write hi/lo, done=1 for that cycle, go to IDLE.
//  busy=1 from after edge N until edge N+WIDTH+1 (WIDTH+1 cycles); busy=0 in the done cycle.
//  A new start is legal in the done cycle.
//  start while busy: ignored. start with mtHi/mtLo in the same IDLE cycle: start wins, mt dropped.
//  mtHi/mtLo while busy: ignored. mtHi+mtLo together: both written.
//  MULT/MULTU results:
//   - 2*WIDTH-bit product; hi = upper half, lo = lower half.
//   - Signed: negate the 2*WIDTH product if sign(srcA)^sign(srcB).
//  DIV/DIVU results:
//   - lo = quotient, hi = remainder.
//   - Signed: quotient negated if signs differ; remainder takes the dividend sign.
//   - Truncation is toward zero.
//  Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (WIDTH truncation of the magnitude result).
//  Divide by zero: full latency kept; hi/lo unchanged; divZero=1 with done. divZero=0 for all other ops.
//  Magnitude arithmetic: WIDTH+1-bit remainder for the restoring subtract; 2*WIDTH-bit product accumulator.
// CONFIGURATION
//  MDU_DIV_EN defined: DIV/DIVU behave as above.
//  MDU_DIV_EN undefined: no divider logic.
//   - DIV/DIVU with start go IDLE->FIN directly.
//   - done pulses at edge N+1; hi/lo unchanged; divZero=0; busy=1 for one cycle.
//  MULT/MULTU are identical in both builds.
// STRUCTURE
//  Shared package mdu_pkg:
//   - op encodings (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU)
//   - state enum (S_IDLE, S_RUN, S_FIN)
//   - MDU_ITER = WIDTH
//  One sub-module: mdu_step.
//   - Combinational single-iteration datapath: add/shift, or trial-subtract/restore.
//   - Instanced once; driven by the FSM and counter in mul_div_unit.
// TESTING
//  1. MULTU srcA=0xFFFFFFFF, srcB=0xFFFFFFFF -> done 33 cycles after start; hi=0xFFFFFFFE, lo=0x00000001.
//  2. MULT srcA=0xFFFFFFFD(-3), srcB=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
//  3. DIVU 100/7 -> lo=0x0000000E, hi=0x00000002.
//     DIV 0xFFFFFFF9(-7)/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//  4. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
//     DIVU 5/0 after mtHi/mtLo of 0xAAAA5555 -> divZero=1; hi=lo=0xAAAA5555.
//  5. start during busy, and mtLo during busy -> ignored; in-flight result unchanged; lo not written.
//  6. reset low at cycle 10 of a MULT -> hi=lo=0, busy=0 immediately.
//     A fresh MULTU 6*7 then gives lo=42, hi=0.
//     Build without MDU_DIV_EN: DIVU done after 1 cycle, hi/lo unchanged.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// controller states and the default iteration count.
package mdu_pkg;

    localparam int MDU_ITER = 32;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } mdu_state_e;

    function automatic logic op_is_div(input mdu_op_e op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic op_is_signed(input mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add multiply step, or (with MDU_DIV_EN) a
// restoring-divide step. acc holds {upper, lower}; lower is the multiplier / quotient.
module mdu_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_ITER
) (
`ifdef MDU_DIV_EN
    input  logic                 is_div_i,
`endif
    input  logic [WIDTH-1:0]     opnd_i,
    input  logic [2*WIDTH-1:0]   acc_i,
    output logic [2*WIDTH-1:0]   acc_o
);

    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   mul_next;

    // Carry out of the partial-product add lands in the top bit after the shift.
    assign sum      = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    assign mul_next = {sum, acc_i[WIDTH-1:1]};

`ifdef MDU_DIV_EN
    logic [WIDTH:0]       shifted;
    logic [WIDTH:0]       trial;
    logic [2*WIDTH-1:0]   div_next;

    // Bring the next dividend bit into the remainder, then try the subtract.
    assign shifted  = acc_i[2*WIDTH-1:WIDTH-1];
    assign trial    = shifted - {1'b0, opnd_i};
    assign div_next = trial[WIDTH] ? {shifted[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0}
                                   : {trial[WIDTH-1:0],   acc_i[WIDTH-2:0], 1'b1};

    assign acc_o = is_div_i ? div_next : mul_next;
`else
    assign acc_o = mul_next;
`endif

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding architectural HI/LO.
// Define MDU_DIV_EN to build the divider; otherwise DIV/DIVU complete in one cycle with no effect.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_ITER
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             mtHi,
    input  logic             mtLo,
    output logic             busy,
    output logic             done,
    output logic             divZero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);

    mdu_state_e           state_q, state_d;
    mdu_op_e              op_q, op_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic                 neg_q, neg_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;
    logic                 divzero_q, divzero_d;
`ifdef MDU_DIV_EN
    logic                 rneg_q, rneg_d;
    logic                 dz_q, dz_d;
    logic [WIDTH-1:0]     quot_fix;
    logic [WIDTH-1:0]     rem_fix;
`endif

    mdu_op_e              op_in;
    logic                 in_signed;
    logic                 in_div;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [2*WIDTH-1:0]   step_acc;
    logic [2*WIDTH-1:0]   prod_fix;

    assign op_in     = mdu_op_e'(op);
    assign in_signed = op_is_signed(op_in);
    assign in_div    = op_is_div(op_in);
    // -MIN wraps to MIN, which is still the correct unsigned magnitude.
    assign a_mag     = (in_signed && srcA[WIDTH-1]) ? -srcA : srcA;
    assign b_mag     = (in_signed && srcB[WIDTH-1]) ? -srcB : srcB;

    assign prod_fix  = neg_q ? -acc_q : acc_q;
`ifdef MDU_DIV_EN
    assign quot_fix  = neg_q  ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
    assign rem_fix   = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`endif

    mdu_step #(.WIDTH(WIDTH)) u_step (
`ifdef MDU_DIV_EN
        .is_div_i (op_is_div(op_q)),
`endif
        .opnd_i   (opnd_q),
        .acc_i    (acc_q),
        .acc_o    (step_acc)
    );

    always_comb begin
        // NOTE: every variable gets its hold value first, so no path can infer a latch.
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        neg_d     = neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        divzero_d = 1'b0;
`ifdef MDU_DIV_EN
        rneg_d    = rneg_q;
        dz_d      = dz_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op_in;
                    cnt_d   = '0;
                    opnd_d  = in_div ? b_mag : a_mag;
                    acc_d   = {{WIDTH{1'b0}}, (in_div ? a_mag : b_mag)};
                    neg_d   = in_signed && (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
`ifdef MDU_DIV_EN
                    rneg_d  = in_signed && srcA[WIDTH-1];
                    dz_d    = in_div && (srcB == '0);
                    state_d = S_RUN;
`else
                    state_d = in_div ? S_FIN : S_RUN;
`endif
                end else begin
                    if (mtHi) hi_d = srcA;
                    if (mtLo) lo_d = srcA;
                end
            end

            S_RUN: begin
                acc_d = step_acc;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIN;
            end

            S_FIN: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (!op_is_div(op_q)) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
`ifdef MDU_DIV_EN
                else if (dz_q) begin
                    divzero_d = 1'b1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end
`endif
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the datapath registers are reset too; they are few and it keeps
    // simulation free of X after an abort.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            op_q      <= MDU_MULT;
            cnt_q     <= '0;
            opnd_q    <= '0;
            acc_q     <= '0;
            neg_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
`ifdef MDU_DIV_EN
            rneg_q    <= 1'b0;
            dz_q      <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            neg_q     <= neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            divzero_q <= divzero_d;
`ifdef MDU_DIV_EN
            rneg_q    <= rneg_d;
            dz_q      <= dz_d;
`endif
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign divZero = divzero_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit; covers both MDU_DIV_EN builds.
module tb_mul_div_unit;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         clk   = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op    = 2'b00;
    logic [W-1:0] srcA  = '0;
    logic [W-1:0] srcB  = '0;
    logic         mtHi  = 1'b0;
    logic         mtLo  = 1'b0;
    logic         busy, done, divZero;
    logic [W-1:0] hi, lo;

    int total = 0;
    int bad   = 0;
    int lat;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .srcA    (srcA),
        .srcB    (srcB),
        .mtHi    (mtHi),
        .mtLo    (mtLo),
        .busy    (busy),
        .done    (done),
        .divZero (divZero),
        .hi      (hi),
        .lo      (lo)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; leaves at the negedge right after the accepting posedge.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        op    = o;
        srcA  = a;
        srcB  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [W-1:0] a, input logic [W-1:0] b, input int exp_lat,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo, input logic exp_dz);
        int n;
        issue(o, a, b);
        check({tag, ".busy_on"}, W'(busy), W'(1));
        wait_done(n);
        check({tag, ".latency"}, W'(n), W'(exp_lat));
        check({tag, ".busy_off"}, W'(busy), W'(0));
        check({tag, ".hi"}, hi, exp_hi);
        check({tag, ".lo"}, lo, exp_lo);
        check({tag, ".divZero"}, W'(divZero), W'(exp_dz));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst.hi", hi, '0);
        check("rst.lo", lo, '0);
        check("rst.busy", W'(busy), W'(0));
        check("rst.done", W'(done), W'(0));
        check("rst.divZero", W'(divZero), W'(0));
        reset = 1'b1;
        @(negedge clk);

        // Back-to-back ops: each new start lands in the previous done cycle.
        run_op("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("mult_neg",  MDU_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 33, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        run_op("mult_nn",   MDU_MULT,  32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 32'h0000_0000, 32'h0000_0006, 1'b0);
        run_op("mult_min",  MDU_MULT,  32'h8000_0000, 32'h8000_0000, 33, 32'h4000_0000, 32'h0000_0000, 1'b0);
        run_op("multu_msb", MDU_MULTU, 32'h8000_0000, 32'h0000_0002, 33, 32'h0000_0001, 32'h0000_0000, 1'b0);
        @(negedge clk);
        check("done_pulse", W'(done), W'(0));

`ifdef MDU_DIV_EN
        run_op("divu_100_7", MDU_DIVU, 32'd100,        32'd7,          33, 32'h0000_0002, 32'h0000_000E, 1'b0);
        run_op("div_m7_2",   MDU_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("div_7_m2",   MDU_DIV,  32'h0000_0007, 32'hFFFF_FFFE, 33, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
        run_op("div_ovf",    MDU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0000_0000, 32'h8000_0000, 1'b0);
`endif

        // Both move-to writes in one idle cycle.
        srcA = 32'hAAAA_5555;
        mtHi = 1'b1;
        mtLo = 1'b1;
        @(negedge clk);
        mtHi = 1'b0;
        mtLo = 1'b0;
        check("mt.hi", hi, 32'hAAAA_5555);
        check("mt.lo", lo, 32'hAAAA_5555);

`ifdef MDU_DIV_EN
        run_op("divu_zero", MDU_DIVU, 32'd5, 32'd0, 33, 32'hAAAA_5555, 32'hAAAA_5555, 1'b1);
        @(negedge clk);
        check("divZero_pulse", W'(divZero), W'(0));
`else
        run_op("divu_nodiv", MDU_DIVU, 32'd100, 32'd7, 1, 32'hAAAA_5555, 32'hAAAA_5555, 1'b0);
        run_op("div_nodiv",  MDU_DIV,  32'd9,   32'd0, 1, 32'hAAAA_5555, 32'hAAAA_5555, 1'b0);
`endif

        // start together with mtHi/mtLo: the op is taken, the moves are dropped.
        mtHi = 1'b1;
        mtLo = 1'b1;
        issue(MDU_MULTU, 32'd2, 32'd3);
        mtHi = 1'b0;
        mtLo = 1'b0;
        check("startwins.hi", hi, 32'hAAAA_5555);
        check("startwins.lo", lo, 32'hAAAA_5555);
        wait_done(lat);
        check("startwins.res_hi", hi, 32'd0);
        check("startwins.res_lo", lo, 32'd6);

        // start and mtLo while busy are both ignored.
        issue(MDU_MULTU, 32'd3, 32'd4);
        repeat (4) @(negedge clk);
        op    = MDU_MULT;
        srcA  = 32'h0000_1234;
        srcB  = 32'd100;
        start = 1'b1;
        mtLo  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mtLo  = 1'b0;
        check("busyign.lo_held", lo, 32'd6);
        wait_done(lat);
        check("busyign.latency", W'(lat + 5), W'(33));
        check("busyign.hi", hi, 32'd0);
        check("busyign.lo", lo, 32'd12);
        repeat (3) @(negedge clk);
        check("busyign.no_restart", W'(busy), W'(0));
        check("busyign.no_done", W'(done), W'(0));

        // Asynchronous reset in the middle of a multiply.
        issue(MDU_MULT, 32'd7, 32'd9);
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort.hi", hi, 32'd0);
        check("abort.lo", lo, 32'd0);
        check("abort.busy", W'(busy), W'(0));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_op("post_reset", MDU_MULTU, 32'd6, 32'd7, 33, 32'd0, 32'd42, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
